sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Sequences the single-port 128b x 2048 activation/psum SRAM.
- Shares it between a write requester (accumulator/SFP output path) and a read requester (L0/ofifo refill path).
- Includes a built-in region-clear engine that zero-fills a contiguous address range before a new layer.
- Sits directly in front of the SRAM macro and drives its active-low CEN/WEN, address and data pins.

Parameters:
ADDR_W, 11, SRAM address width (depth = 2**ADDR_W)
DATA_W, 128, SRAM word width
RR_INIT, 0, round-robin pointer value after reset (0 = write preferred first, 1 = read preferred first)

Ports:
CLK  input  1  clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
wr_req  input  1  write request, held until granted
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_gnt  output  1  write accepted this cycle (combinational)
rd_req  input  1  read request, held until granted
rd_addr  input  ADDR_W  read address
rd_gnt  output  1  read accepted this cycle (combinational)
rd_valid  output  1  read data valid, one cycle after rd_gnt
rd_data  output  DATA_W  read data, meaningful only while rd_valid
clr_start  input  1  one-cycle pulse, start clear
clr_base  input  ADDR_W  first address to clear
clr_len  input  ADDR_W+1  number of words to clear, 0..2**ADDR_W
clr_busy  output  1  clear engine active
clr_done  output  1  one-cycle pulse, clear complete
sram_cen  output  1  SRAM chip enable, active low
sram_wen  output  1  SRAM write enable, active low
sram_a  output  ADDR_W  SRAM address
sram_d  output  DATA_W  SRAM write data
sram_q  input  DATA_W  SRAM read data

Behaviour:
- Reset (RESET_N low, async):
  - FSM in IDLE; rr_ptr = RR_INIT; rd_valid = 0; clr_busy = 0; clr_done = 0.
  - wr_gnt, rd_gnt forced 0; sram_cen = 1, sram_wen = 1; sram_a = 0; sram_d = 0.
- SRAM timing contract:
  - Write commits at the edge ending the grant cycle.
  - Read address latches at the edge ending the grant cycle; sram_q is valid throughout the next cycle.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start with clr_len != 0. Load clr_ptr = clr_base and clr_cnt = clr_len.
  - IDLE -> DONE on clr_start with clr_len == 0. No SRAM access.
  - CLEAR: each cycle drive cen=0, wen=0, a=clr_ptr, d=0. Then clr_ptr++ (wraps modulo 2**ADDR_W, 2047 -> 0) and clr_cnt--. When clr_cnt == 1 at the edge -> DONE.
  - DONE: clr_done = 1 for exactly one cycle, then -> IDLE. Arbitration is live in DONE.
  - clr_busy = 1 in CLEAR only.
  - clr_start outside IDLE is ignored.
  - clr_start in IDLE has priority over requesters in that cycle: no grants are issued and the FSM moves to CLEAR.
- Arbitration (IDLE and DONE only; no grants in CLEAR; requesters simply wait):
  - Only wr_req -> wr_gnt. Only rd_req -> rd_gnt.
  - Both requesting -> rr_ptr=0 grants write, rr_ptr=1 grants read. rr_ptr then flips to the loser.
  - rr_ptr updates only on contended cycles.
  - At most one grant per cycle. Each grant corresponds to exactly one SRAM access that cycle.
- SRAM pins:
  - Write grant: cen=0, wen=0, a=wr_addr, d=wr_data.
  - Read grant: cen=0, wen=1, a=rd_addr, d=0.
  - No access: cen=1, wen=1, a=0, d=0.
  - sram_* outputs are combinational from state and requests.
- Read return:
  - rd_valid is a registered copy of rd_gnt.
  - rd_data = sram_q passthrough, 1-cycle latency.
  - A write granted in the rd_valid cycle to the same address does not alter rd_data in that cycle.
- Back-to-back reads are allowed: rd_valid is high for consecutive cycles.
- Reset mid-clear: the clear aborts immediately, no clr_done is issued, and partially cleared words stay zero.

Test Plan:
- Reset then single write: wr_req=1, wr_addr=0x005, wr_data=0xA5..A5. Required: wr_gnt=1 same cycle, sram_cen=0, sram_wen=0, sram_a=0x005. Then rd 0x005: rd_valid next cycle, rd_data=0xA5..A5.
- Contention: wr_req and rd_req held high 4 cycles, RR_INIT=0. Required: grant sequence W,R,W,R; exactly one sram access per cycle; rd_valid high in the cycle after each R.
- Clear with wrap: clr_base=0x7FE, clr_len=4. Required: clr_busy high 4 cycles, addresses 0x7FE,0x7FF,0x000,0x001 written with 0, clr_done pulse in the next cycle. A rd_req held throughout is granted only in the clr_done cycle or later, and reading 0x000 returns 0.
- Zero-length clear: clr_start with clr_len=0. Required: no sram_cen low, clr_busy stays 0, clr_done pulses one cycle later.
- Ignored restart: second clr_start during CLEAR (clr_len=8). Required: exactly 8 writes total, single clr_done.
- Async reset at clear word 3 of 8. Required: sram_cen=1 immediately, clr_busy=0, no clr_done; words 0-2 read back 0, words 3-7 retain old data.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Front end for the single-port activation/psum SRAM. It arbitrates between a
// write requester and a read requester with a round-robin tie-break, and it
// contains a region-clear engine that zero-fills a contiguous (wrapping)
// address range. SRAM pins are active-low CEN/WEN and are driven
// combinationally so that each grant maps onto exactly one access in the same
// cycle.
module sram_port_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 128,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W:0]   clr_len,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t              state_r;
    logic                rr_ptr_r;
    logic [ADDR_W-1:0]   clr_ptr_r;
    logic [ADDR_W:0]     clr_cnt_r;
    logic                clr_busy_r;
    logic                clr_done_r;
    logic                rd_valid_r;

    logic                arb_en_s;
    logic                contend_s;
    logic                wr_gnt_s;
    logic                rd_gnt_s;
    logic                cen_s;
    logic                wen_s;
    logic [ADDR_W-1:0]   a_s;
    logic [DATA_W-1:0]   d_s;

    // Decide whether grants may be issued this cycle and who wins.
    always_comb begin
        arb_en_s = 1'b0;
        if (!RESET_N) begin
            arb_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  arb_en_s = !clr_start;  // a clear start pre-empts requesters
                ST_DONE:  arb_en_s = 1'b1;
                ST_CLEAR: arb_en_s = 1'b0;
                default:  arb_en_s = 1'b0;
            endcase
        end
        contend_s = wr_req && rd_req;
        wr_gnt_s  = arb_en_s && wr_req && (!rd_req || !rr_ptr_r);
        rd_gnt_s  = arb_en_s && rd_req && (!wr_req ||  rr_ptr_r);
    end

    // Map the active operation (clear, write grant, read grant) onto SRAM pins.
    always_comb begin
        cen_s = 1'b1;
        wen_s = 1'b1;
        a_s   = '0;
        d_s   = '0;
        if (RESET_N && (state_r == ST_CLEAR)) begin
            cen_s = 1'b0;
            wen_s = 1'b0;
            a_s   = clr_ptr_r;
            d_s   = '0;
        end else if (wr_gnt_s) begin
            cen_s = 1'b0;
            wen_s = 1'b0;
            a_s   = wr_addr;
            d_s   = wr_data;
        end else if (rd_gnt_s) begin
            cen_s = 1'b0;
            wen_s = 1'b1;
            a_s   = rd_addr;
            d_s   = '0;
        end else begin
            cen_s = 1'b1;
            wen_s = 1'b1;
            a_s   = '0;
            d_s   = '0;
        end
    end

    // Clear-engine FSM with registered busy/done flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            clr_ptr_r  <= '0;
            clr_cnt_r  <= '0;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_start) begin
                        if (clr_len != '0) begin
                            state_r    <= ST_CLEAR;
                            clr_ptr_r  <= clr_base;
                            clr_cnt_r  <= clr_len;
                            clr_busy_r <= 1'b1;
                        end else begin
                            state_r    <= ST_DONE;
                            clr_done_r <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    // Pointer wraps naturally at the top of the address space.
                    clr_ptr_r <= clr_ptr_r + ADDR_ONE;
                    clr_cnt_r <= clr_cnt_r - CNT_ONE;
                    if (clr_cnt_r == CNT_ONE) begin
                        state_r    <= ST_DONE;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    clr_done_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer moves to the loser only on contended grant cycles.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rr_ptr_r <= RR_INIT;
        end else if (arb_en_s && contend_s) begin
            rr_ptr_r <= ~rr_ptr_r;
        end
    end

    // Read data is valid the cycle after the read grant.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_gnt_s;
        end
    end

    assign wr_gnt   = wr_gnt_s;
    assign rd_gnt   = rd_gnt_s;
    assign rd_valid = rd_valid_r;
    assign rd_data  = sram_q;
    assign clr_busy = clr_busy_r;
    assign clr_done = clr_done_r;
    assign sram_cen = cen_s;
    assign sram_wen = wen_s;
    assign sram_a   = a_s;
    assign sram_d   = d_s;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: a behavioural SRAM model, a table of
// per-cycle vectors for arbitration, and directed sequences for the clear engine.
module tb_sram_port_arbiter;

    logic         CLK;
    logic         RESET_N;
    logic         wr_req;
    logic [10:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_gnt;
    logic         rd_req;
    logic [10:0]  rd_addr;
    logic         rd_gnt;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         clr_start;
    logic [10:0]  clr_base;
    logic [11:0]  clr_len;
    logic         clr_busy;
    logic         clr_done;
    logic         sram_cen;
    logic         sram_wen;
    logic [10:0]  sram_a;
    logic [127:0] sram_d;
    logic [127:0] sram_q;

    int n_cmp;
    int n_err;
    int wr_cnt;
    int done_cnt;

    logic [127:0] mem [0:2047];

    sram_port_arbiter dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port SRAM model: synchronous write, registered read data.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    // Count SRAM writes and clear-done pulses.
    always @(posedge CLK) begin
        if (!sram_cen && !sram_wen) wr_cnt <= wr_cnt + 1;
        if (clr_done)               done_cnt <= done_cnt + 1;
    end

    typedef struct packed {
        logic         wr_req;
        logic         rd_req;
        logic [10:0]  wr_addr;
        logic [10:0]  rd_addr;
        logic [127:0] wr_data;
        logic         e_wgnt;
        logic         e_rgnt;
        logic         e_cen;
        logic         e_wen;
        logic [10:0]  e_a;
        logic [127:0] e_d;
        logic         e_rv;
        logic         chk_rd;
        logic [127:0] e_rdata;
    } vec_t;

    vec_t vtab [0:31];
    int   nvec;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic wq, input logic rq, input logic [10:0] wa,
                           input logic [10:0] ra, input logic [127:0] wd,
                           input logic eg, input logic er, input logic ec, input logic ew,
                           input logic [10:0] ea, input logic [127:0] ed,
                           input logic erv, input logic ck, input logic [127:0] erd);
        vtab[nvec] = '{wq, rq, wa, ra, wd, eg, er, ec, ew, ea, ed, erv, ck, erd};
        nvec++;
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [127:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        @(negedge CLK);
        check("prefill_wr_gnt", {127'd0, wr_gnt}, 128'd1);
        next_cyc();
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [10:0] a, input logic [127:0] exp);
        rd_req = 1'b1; rd_addr = a;
        @(negedge CLK);
        check("rb_rd_gnt", {127'd0, rd_gnt}, 128'd1);
        next_cyc();
        rd_req = 1'b0;
        @(negedge CLK);
        check("rb_rd_valid", {127'd0, rd_valid}, 128'd1);
        check("rb_rd_data", rd_data, exp);
        next_cyc();
    endtask

    localparam logic [127:0] PA5 = {16{8'hA5}};
    localparam logic [127:0] P11 = {16{8'h11}};
    localparam logic [127:0] P22 = {16{8'h22}};
    localparam logic [127:0] P33 = {16{8'h33}};
    localparam logic [127:0] P44 = {16{8'h44}};
    localparam logic [127:0] P55 = {16{8'h55}};
    localparam logic [127:0] P77 = {16{8'h77}};
    localparam logic [127:0] PEE = {16{8'hEE}};
    localparam logic [127:0] Z   = 128'd0;

    initial begin
        logic [10:0] ea;
        int          w0;
        int          d0;
        bit          found;

        n_cmp = 0; n_err = 0; nvec = 0;
        wr_cnt = 0; done_cnt = 0;
        sram_q = '0;

        //       wq    rq    waddr    raddr    wdata  wg    rg    cen   wen   a        d    rv    chk   rdata
        add_vec(1'b0, 1'b0, 11'h000, 11'h000, Z,   1'b0, 1'b0, 1'b1, 1'b1, 11'h000, Z,   1'b0, 1'b0, Z);
        add_vec(1'b1, 1'b0, 11'h005, 11'h000, PA5, 1'b1, 1'b0, 1'b0, 1'b0, 11'h005, PA5, 1'b0, 1'b0, Z);
        add_vec(1'b0, 1'b1, 11'h000, 11'h005, Z,   1'b0, 1'b1, 1'b0, 1'b1, 11'h005, Z,   1'b0, 1'b0, Z);
        add_vec(1'b0, 1'b0, 11'h000, 11'h000, Z,   1'b0, 1'b0, 1'b1, 1'b1, 11'h000, Z,   1'b1, 1'b1, PA5);
        add_vec(1'b1, 1'b0, 11'h010, 11'h000, P11, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, P11, 1'b0, 1'b0, Z);
        // contention, pointer starts at write
        add_vec(1'b1, 1'b1, 11'h020, 11'h010, P22, 1'b1, 1'b0, 1'b0, 1'b0, 11'h020, P22, 1'b0, 1'b0, Z);
        add_vec(1'b1, 1'b1, 11'h021, 11'h010, P33, 1'b0, 1'b1, 1'b0, 1'b1, 11'h010, Z,   1'b0, 1'b0, Z);
        add_vec(1'b1, 1'b1, 11'h021, 11'h020, P33, 1'b1, 1'b0, 1'b0, 1'b0, 11'h021, P33, 1'b1, 1'b1, P11);
        add_vec(1'b1, 1'b1, 11'h022, 11'h020, P44, 1'b0, 1'b1, 1'b0, 1'b1, 11'h020, Z,   1'b0, 1'b0, Z);
        add_vec(1'b0, 1'b0, 11'h000, 11'h000, Z,   1'b0, 1'b0, 1'b1, 1'b1, 11'h000, Z,   1'b1, 1'b1, P22);
        // uncontended read leaves pointer at write; then same-address write in rd_valid cycle
        add_vec(1'b0, 1'b1, 11'h000, 11'h021, Z,   1'b0, 1'b1, 1'b0, 1'b1, 11'h021, Z,   1'b0, 1'b0, Z);
        add_vec(1'b1, 1'b0, 11'h021, 11'h000, P77, 1'b1, 1'b0, 1'b0, 1'b0, 11'h021, P77, 1'b1, 1'b1, P33);
        add_vec(1'b1, 1'b1, 11'h030, 11'h021, P55, 1'b1, 1'b0, 1'b0, 1'b0, 11'h030, P55, 1'b0, 1'b0, Z);
        add_vec(1'b0, 1'b1, 11'h000, 11'h021, Z,   1'b0, 1'b1, 1'b0, 1'b1, 11'h021, Z,   1'b0, 1'b0, Z);
        add_vec(1'b0, 1'b1, 11'h000, 11'h030, Z,   1'b0, 1'b1, 1'b0, 1'b1, 11'h030, Z,   1'b1, 1'b1, P77);
        add_vec(1'b0, 1'b0, 11'h000, 11'h000, Z,   1'b0, 1'b0, 1'b1, 1'b1, 11'h000, Z,   1'b1, 1'b1, P55);

        // Reset with a pending write request: nothing may be granted.
        RESET_N = 1'b0;
        wr_req = 1'b1; wr_addr = 11'h005; wr_data = PA5;
        rd_req = 1'b0; rd_addr = '0;
        clr_start = 1'b0; clr_base = '0; clr_len = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_wr_gnt",   {127'd0, wr_gnt},   128'd0);
        check("rst_cen",      {127'd0, sram_cen}, 128'd1);
        check("rst_wen",      {127'd0, sram_wen}, 128'd1);
        check("rst_a",        {117'd0, sram_a},   128'd0);
        check("rst_d",        sram_d,             128'd0);
        check("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
        check("rst_clr_busy", {127'd0, clr_busy}, 128'd0);
        check("rst_clr_done", {127'd0, clr_done}, 128'd0);
        next_cyc();
        RESET_N = 1'b1;
        wr_req  = 1'b0;
        next_cyc();

        // Table-driven arbitration vectors.
        for (int i = 0; i < nvec; i++) begin
            wr_req = vtab[i].wr_req; rd_req = vtab[i].rd_req;
            wr_addr = vtab[i].wr_addr; rd_addr = vtab[i].rd_addr; wr_data = vtab[i].wr_data;
            @(negedge CLK);
            check($sformatf("v%0d_wr_gnt", i), {127'd0, wr_gnt},   {127'd0, vtab[i].e_wgnt});
            check($sformatf("v%0d_rd_gnt", i), {127'd0, rd_gnt},   {127'd0, vtab[i].e_rgnt});
            check($sformatf("v%0d_cen", i),    {127'd0, sram_cen}, {127'd0, vtab[i].e_cen});
            check($sformatf("v%0d_wen", i),    {127'd0, sram_wen}, {127'd0, vtab[i].e_wen});
            check($sformatf("v%0d_a", i),      {117'd0, sram_a},   {117'd0, vtab[i].e_a});
            check($sformatf("v%0d_d", i),      sram_d,             vtab[i].e_d);
            check($sformatf("v%0d_rd_valid", i), {127'd0, rd_valid}, {127'd0, vtab[i].e_rv});
            if (vtab[i].chk_rd) check($sformatf("v%0d_rd_data", i), rd_data, vtab[i].e_rdata);
            next_cyc();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        next_cyc();

        // Clear with address wrap, read requester held throughout.
        do_write(11'h7FE, PEE); do_write(11'h7FF, PEE); do_write(11'h000, PEE);
        do_write(11'h001, PEE); do_write(11'h002, PEE);
        clr_start = 1'b1; clr_base = 11'h7FE; clr_len = 12'd4;
        rd_req = 1'b1; rd_addr = 11'h000;
        @(negedge CLK);
        check("wrap_start_rd_gnt", {127'd0, rd_gnt},   128'd0);
        check("wrap_start_cen",    {127'd0, sram_cen}, 128'd1);
        check("wrap_start_busy",   {127'd0, clr_busy}, 128'd0);
        next_cyc();
        clr_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ea = 11'h7FE + 11'(k);
            @(negedge CLK);
            check($sformatf("wrap%0d_busy", k),   {127'd0, clr_busy}, 128'd1);
            check($sformatf("wrap%0d_cen", k),    {127'd0, sram_cen}, 128'd0);
            check($sformatf("wrap%0d_wen", k),    {127'd0, sram_wen}, 128'd0);
            check($sformatf("wrap%0d_a", k),      {117'd0, sram_a},   {117'd0, ea});
            check($sformatf("wrap%0d_d", k),      sram_d,             128'd0);
            check($sformatf("wrap%0d_rd_gnt", k), {127'd0, rd_gnt},   128'd0);
            check($sformatf("wrap%0d_done", k),   {127'd0, clr_done}, 128'd0);
            next_cyc();
        end
        @(negedge CLK);
        check("wrap_done_pulse",  {127'd0, clr_done}, 128'd1);
        check("wrap_done_busy",   {127'd0, clr_busy}, 128'd0);
        check("wrap_done_rd_gnt", {127'd0, rd_gnt},   128'd1);
        check("wrap_done_a",      {117'd0, sram_a},   128'd0);
        check("wrap_done_wen",    {127'd0, sram_wen}, 128'd1);
        next_cyc();
        rd_req = 1'b0;
        @(negedge CLK);
        check("wrap_rd_valid", {127'd0, rd_valid}, 128'd1);
        check("wrap_rd_data",  rd_data,            128'd0);
        check("wrap_done_end", {127'd0, clr_done}, 128'd0);
        next_cyc();
        do_read(11'h7FE, Z);
        do_read(11'h001, Z);
        do_read(11'h002, PEE);

        // Zero-length clear: done pulse, no SRAM access, never busy.
        clr_start = 1'b1; clr_base = 11'h123; clr_len = 12'd0;
        @(negedge CLK);
        check("zl_start_cen",  {127'd0, sram_cen}, 128'd1);
        check("zl_start_busy", {127'd0, clr_busy}, 128'd0);
        check("zl_start_done", {127'd0, clr_done}, 128'd0);
        next_cyc();
        clr_start = 1'b0;
        @(negedge CLK);
        check("zl_done",      {127'd0, clr_done}, 128'd1);
        check("zl_done_busy", {127'd0, clr_busy}, 128'd0);
        check("zl_done_cen",  {127'd0, sram_cen}, 128'd1);
        next_cyc();
        @(negedge CLK);
        check("zl_done_end", {127'd0, clr_done}, 128'd0);
        next_cyc();

        // Restart during CLEAR is ignored: 8 writes, one done.
        w0 = wr_cnt; d0 = done_cnt;
        clr_start = 1'b1; clr_base = 11'h100; clr_len = 12'd8;
        next_cyc();
        clr_start = 1'b0;
        next_cyc();
        clr_start = 1'b1; clr_base = 11'h200; clr_len = 12'd8;
        next_cyc();
        clr_start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge CLK);
            if (clr_done) found = 1'b1;
            next_cyc();
        end
        check("rs_done_seen", {127'd0, found}, 128'd1);
        next_cyc(); next_cyc(); next_cyc();
        check("rs_write_count", 128'(wr_cnt - w0),   128'd8);
        check("rs_done_count",  128'(done_cnt - d0), 128'd1);

        // Async reset while clearing word 3 of 8.
        for (int i = 0; i < 8; i++) do_write(11'h300 + 11'(i), {{15{8'h3C}}, 8'(i)});
        d0 = done_cnt;
        clr_start = 1'b1; clr_base = 11'h300; clr_len = 12'd8;
        next_cyc();
        clr_start = 1'b0;
        next_cyc(); next_cyc(); next_cyc();
        check("mid_pre_a", {117'd0, sram_a}, 128'h303);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_cen",  {127'd0, sram_cen}, 128'd1);
        check("mid_rst_busy", {127'd0, clr_busy}, 128'd0);
        check("mid_rst_done", {127'd0, clr_done}, 128'd0);
        next_cyc();
        RESET_N = 1'b1;
        next_cyc(); next_cyc(); next_cyc();
        check("mid_no_done", 128'(done_cnt - d0), 128'd0);
        for (int i = 0; i < 8; i++) begin
            if (i < 3) do_read(11'h300 + 11'(i), Z);
            else       do_read(11'h300 + 11'(i), {{15{8'h3C}}, 8'(i)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
